nabp_filtered_ram_bank_ring: RTL
================================

Name: nabp_filtered_ram_bank_ring

Overview:
- Parametrised successor to the two-bank filtered-RAM ping-pong controller.
- Manages a ring of NUM_BANKS filtered-projection banks. Each bank holds one angle's filtered data.
- Host/FIR side fills banks ahead of the processing side, so up to NUM_BANKS-1 angles are prefetched.
- Routes read data from the working bank to NUM_PR processing ports and the fill address from the filling bank to the host RAM.

Parameters:
NUM_BANKS, 3, number of banks in the ring (2..8); 2 gives classic ping-pong behaviour
NUM_PR, 2, number of processing read ports
S_W, 9, projection sample address width
DATA_W, 16, filtered data width (signed)
ANGLE_W, 8, angle index width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
hs_angle  in  ANGLE_W  angle offered by host
hs_has_next_angle  in  1  host has a further angle to supply
hs_next_angle  out  1  request for next angle from host
hs_next_angle_ack  in  1  host accepts request; hs_angle valid this cycle
bank_fill_kick  out  NUM_BANKS  one-hot, 1-cycle fill start per bank
bank_fill_done  in  NUM_BANKS  1-cycle fill completion per bank
bank_hs_s_val  in  NUM_BANKS*S_W  per-bank host RAM address
hs_s_val  out  S_W  address of the bank being filled
bank_pr_val  in  NUM_BANKS*NUM_PR*DATA_W  per-bank processing data
pr_val  out  NUM_PR*DATA_W  data from the working bank
pr_next_angle  in  1  processing level request: current angle finished
pr_next_angle_ack  out  1  1-cycle grant; pr_angle updated
pr_angle  out  ANGLE_W  angle of the working bank
all_done  out  1  1-cycle pulse when the final angle is released
occupancy  out  clog2(NUM_BANKS+1)  number of banks FILLING or FULL

Behaviour:
- Per-bank state: EMPTY, FILLING, FULL, WORKING.
- Pointers: fill_ptr, work_ptr (next bank to work), work_sel (current working bank), work_valid flag.
- Reset values: all banks EMPTY; fill_ptr=work_ptr=work_sel=0; work_valid=0; pr_angle=0.
- Reset outputs: hs_next_angle=0, bank_fill_kick=0, pr_next_angle_ack=0, all_done=0, occupancy=0.
- Reset mid-operation clears everything in the next cycle. Pending kicks are dropped and incoming fill_done is ignored.
- Fill side:
  - hs_next_angle = reset_n && bank[fill_ptr]==EMPTY && hs_has_next_angle && no bank FILLING. This is combinational from registered state.
  - Ack is honoured only when hs_next_angle=1. On ack: angle_reg[fill_ptr]<=hs_angle, bank→FILLING, and bank_fill_kick[fill_ptr] pulses in the following cycle (registered).
  - bank_fill_done[fill_ptr] while FILLING: bank→FULL and fill_ptr wraps mod NUM_BANKS. fill_done on a non-FILLING bank is ignored.
- Work side:
  - pr_next_angle=1 and bank[work_ptr]==FULL: pr_next_angle_ack=1 the same cycle (Mealy).
  - In that cycle: previous work_sel bank (if work_valid) → EMPTY; bank[work_ptr]→WORKING.
  - Registered on the next edge: pr_angle<=angle_reg[work_ptr], work_sel<=work_ptr, work_valid<=1, work_ptr wraps.
  - pr_next_angle=1 with bank[work_ptr] not FULL: no ack; wait (stall).
  - Drain: pr_next_angle=1, work_valid=1, hs_has_next_angle=0, no bank FILLING/FULL, and no ack this cycle → working bank→EMPTY, work_valid<=0, all_done pulses 1 cycle.
- Simultaneous events:
  - A bank released in cycle t reads EMPTY from t+1. hs_next_angle for that bank can rise no earlier than t+1.
  - fill_done and ack on different banks in the same cycle are both honoured.
  - Full ring (no EMPTY bank): hs_next_angle=0.
- Muxing (combinational, zero latency):
  - pr_val = bank_pr_val slice at work_sel.
  - hs_s_val = bank_hs_s_val slice at fill_ptr.
  - When work_valid=0, pr_val is 0.
- occupancy is a registered count of FILLING+FULL banks and never exceeds NUM_BANKS.

Optional Feature:
- Macro NABP_FRAM_STALL_STATS_EN.
- Defined: adds outputs stall_pr (16 bits) and stall_hs (16 bits), both saturating at 0xFFFF and cleared by reset.
  - stall_pr counts cycles with pr_next_angle=1, no ack and no drain.
  - stall_hs counts cycles with hs_has_next_angle=1 and the ring full.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- NUM_BANKS=3, host angles 5,6,7; each fill takes 10 cycles, pr_next_angle tied high → acks in order with pr_angle=5,6,7. all_done pulses once after the third release. occupancy peaks at 1.
- Slow processing (pr_next_angle every 100 cycles), angles 1..4 → hs_next_angle deasserts once 3 banks are FULL/WORKING (2 FULL + 1 WORKING). The 4th request follows the first release.
- pr_next_angle high while the next bank is FILLING → no ack until 1 cycle after bank_fill_done. pr_val stays on the old bank until the ack.
- Fill wrap: 7 angles with NUM_BANKS=3 → fill_ptr sequence 0,1,2,0,1,2,0 and one-hot bank_fill_kick pulses in that order.
- reset_n low for 1 cycle mid-fill of bank 1 → next cycle all outputs at reset values. A later bank_fill_done[1] is ignored.
- With NABP_FRAM_STALL_STATS_EN: 20-cycle processing stall → stall_pr=20. Preload stall_pr to 0xFFFF, then stall again → stays at 0xFFFF.

Source files
------------

// File: rtl/nabp_filtered_ram_bank_ring.sv
// -----------------------------------------------------------------------------
// nabp_filtered_ram_bank_ring
//
// Purpose: manages a ring of NUM_BANKS filtered-projection banks. Each bank holds
// one angle's filtered data. The host/FIR side fills banks ahead of the
// processing side, so up to NUM_BANKS-1 angles can be prefetched. Read data
// comes from the working bank and goes to the NUM_PR processing ports. The fill
// address comes from the bank being filled and goes to the host RAM.
// NUM_BANKS=2 gives the classic ping-pong behaviour.
//
// Handshakes:
//   Host side : hs_next_angle is a request and hs_next_angle_ack is the accept.
//               A transfer occurs only in a cycle where both are 1. hs_angle is
//               sampled in that cycle. An ack without a request is ignored.
//   Work side : pr_next_angle is a level request. pr_next_angle_ack is a
//               same-cycle grant. pr_angle and pr_val switch on the next edge.
//
// Ports:
//   clk, reset_n       clock and synchronous active-low reset
//   hs_*               host angle request/ack; hs_s_val is the fill address
//   bank_fill_kick     one-hot, 1-cycle fill start for the bank just accepted
//   bank_fill_done     1-cycle per-bank fill completion
//   bank_hs_s_val      per-bank host RAM address (flattened)
//   bank_pr_val        per-bank processing data (flattened)
//   pr_val             data of the working bank (0 when none is working)
//   pr_next_angle(_ack), pr_angle
//                      work-side request/grant and the current angle
//   all_done           1-cycle pulse when the final angle is released
//   occupancy          registered count of FILLING + FULL banks
//
// Optional feature (macro NABP_FRAM_STALL_STATS_EN):
//   stall_pr           saturating count of stalled processing requests
//   stall_hs           saturating count of host-ready cycles with the ring full
// -----------------------------------------------------------------------------
module nabp_filtered_ram_bank_ring #(
  parameter int NUM_BANKS = 3,
  parameter int NUM_PR    = 2,
  parameter int S_W       = 9,
  parameter int DATA_W    = 16,
  parameter int ANGLE_W   = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [ANGLE_W-1:0]                  hs_angle,
  input  logic                                hs_has_next_angle,
  output logic                                hs_next_angle,
  input  logic                                hs_next_angle_ack,
  output logic [NUM_BANKS-1:0]                bank_fill_kick,
  input  logic [NUM_BANKS-1:0]                bank_fill_done,
  input  logic [NUM_BANKS*S_W-1:0]            bank_hs_s_val,
  output logic [S_W-1:0]                      hs_s_val,
  input  logic [NUM_BANKS*NUM_PR*DATA_W-1:0]  bank_pr_val,
  output logic [NUM_PR*DATA_W-1:0]            pr_val,
  input  logic                                pr_next_angle,
  output logic                                pr_next_angle_ack,
  output logic [ANGLE_W-1:0]                  pr_angle,
  output logic                                all_done,
  output logic [$clog2(NUM_BANKS+1)-1:0]      occupancy
`ifdef NABP_FRAM_STALL_STATS_EN
  ,
  output logic [15:0]                         stall_pr,
  output logic [15:0]                         stall_hs
`endif
);

  localparam int PTR_W = $clog2(NUM_BANKS);
  localparam int OCC_W = $clog2(NUM_BANKS+1);
  localparam int PR_W  = NUM_PR*DATA_W;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_WORKING = 2'd3
  } bank_state_e;

  bank_state_e          r_bank_state [NUM_BANKS];
  bank_state_e          w_bank_next  [NUM_BANKS];
  logic [ANGLE_W-1:0]   r_angle      [NUM_BANKS];
  logic [PTR_W-1:0]     r_fill_ptr;
  logic [PTR_W-1:0]     r_work_ptr;
  logic [PTR_W-1:0]     r_work_sel;
  logic                 r_work_valid;
  logic [ANGLE_W-1:0]   r_pr_angle;
  logic [NUM_BANKS-1:0] r_fill_kick;
  logic [OCC_W-1:0]     r_occupancy;
  logic [OCC_W-1:0]     w_occ_next;

  logic w_any_filling, w_any_busy, w_ring_full;
  logic w_hs_req, w_hs_take, w_fill_done, w_pr_ack, w_drain;

  logic [PR_W-1:0] w_pr_slice [NUM_BANKS];
  logic [S_W-1:0]  w_hs_slice [NUM_BANKS];

  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_BANKS-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ring-wide summaries of the registered bank states.
  always_comb begin
    w_any_filling = 1'b0;
    w_any_busy    = 1'b0;
    w_ring_full   = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_bank_state[b] == BANK_FILLING) w_any_filling = 1'b1;
      if (r_bank_state[b] == BANK_FILLING || r_bank_state[b] == BANK_FULL) w_any_busy = 1'b1;
      if (r_bank_state[b] == BANK_EMPTY) w_ring_full = 1'b0;
    end
  end

  // Only one fill is in flight at a time, so fill_ptr always names that bank.
  assign w_hs_req    = reset_n && (r_bank_state[r_fill_ptr] == BANK_EMPTY) &&
                       hs_has_next_angle && !w_any_filling;
  assign w_hs_take   = w_hs_req && hs_next_angle_ack;
  assign w_fill_done = reset_n && bank_fill_done[r_fill_ptr] &&
                       (r_bank_state[r_fill_ptr] == BANK_FILLING);
  assign w_pr_ack    = reset_n && pr_next_angle && (r_bank_state[r_work_ptr] == BANK_FULL);
  // Drain: nothing left to fetch or process, so release the last working bank.
  assign w_drain     = reset_n && pr_next_angle && r_work_valid && !hs_has_next_angle &&
                       !w_any_busy && !w_pr_ack;

  // Bank state transitions. A take and a completion can never hit the same bank
  // (a take needs EMPTY, a completion needs FILLING). The released bank is
  // WORKING and the new working bank is FULL, so the four updates are disjoint.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) w_bank_next[b] = r_bank_state[b];
    if (w_hs_take)                          w_bank_next[r_fill_ptr] = BANK_FILLING;
    if (w_fill_done)                        w_bank_next[r_fill_ptr] = BANK_FULL;
    if ((w_pr_ack || w_drain) && r_work_valid) w_bank_next[r_work_sel] = BANK_EMPTY;
    if (w_pr_ack)                           w_bank_next[r_work_ptr] = BANK_WORKING;
  end

  // Occupancy is counted from the next state, so the register tracks the
  // current bank states exactly.
  always_comb begin
    w_occ_next = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_bank_next[b] == BANK_FILLING || w_bank_next[b] == BANK_FULL)
        w_occ_next = w_occ_next + OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_bank_state[b] <= BANK_EMPTY;
        r_angle[b]      <= '0;
      end
      r_fill_ptr   <= '0;
      r_work_ptr   <= '0;
      r_work_sel   <= '0;
      r_work_valid <= 1'b0;
      r_pr_angle   <= '0;
      r_fill_kick  <= '0;
      r_occupancy  <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) r_bank_state[b] <= w_bank_next[b];
      if (w_hs_take) r_angle[r_fill_ptr] <= hs_angle;
      r_fill_kick <= w_hs_take ? (NUM_BANKS'(1) << r_fill_ptr) : '0;
      if (w_fill_done) r_fill_ptr <= f_next_ptr(r_fill_ptr);
      if (w_pr_ack) begin
        r_pr_angle   <= r_angle[r_work_ptr];
        r_work_sel   <= r_work_ptr;
        r_work_valid <= 1'b1;
        r_work_ptr   <= f_next_ptr(r_work_ptr);
      end else if (w_drain) begin
        r_work_valid <= 1'b0;
      end
      r_occupancy <= w_occ_next;
    end
  end

  // Zero-latency data routing.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_pr_slice[b] = bank_pr_val[b*PR_W +: PR_W];
      w_hs_slice[b] = bank_hs_s_val[b*S_W +: S_W];
    end
  end

  assign pr_val            = r_work_valid ? w_pr_slice[r_work_sel] : '0;
  assign hs_s_val          = w_hs_slice[r_fill_ptr];
  assign hs_next_angle     = w_hs_req;
  assign bank_fill_kick    = r_fill_kick;
  assign pr_next_angle_ack = w_pr_ack;
  assign pr_angle          = r_pr_angle;
  assign all_done          = w_drain;
  assign occupancy         = r_occupancy;

`ifdef NABP_FRAM_STALL_STATS_EN
  logic [15:0] r_stall_pr;
  logic [15:0] r_stall_hs;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_pr <= '0;
      r_stall_hs <= '0;
    end else begin
      if (pr_next_angle && !w_pr_ack && !w_drain && r_stall_pr != 16'hFFFF)
        r_stall_pr <= r_stall_pr + 16'd1;
      if (hs_has_next_angle && w_ring_full && r_stall_hs != 16'hFFFF)
        r_stall_hs <= r_stall_hs + 16'd1;
    end
  end

  assign stall_pr = r_stall_pr;
  assign stall_hs = r_stall_hs;
`endif

endmodule
